// File: rtl/fiber_frame_deframer_if.sv
// Lane-side bundle for the fiber frame deframer.
// Optional checksum build: FIBER_DEFRAME_CSUM_EN.
interface fiber_frame_deframer_if #(
  parameter int CNT_W = 16
);
  logic             lock;
  logic [15:0]      din;
  logic [15:0]      dout;
  logic             dout_valid;
  logic             dout_sof;
  logic             dout_eof;
  logic             frame_ok;
  logic             frame_err;
  logic             in_sync;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output lock, din,
    input  dout, dout_valid, dout_sof, dout_eof,
    input  frame_ok, frame_err, in_sync,
    input  frame_cnt, err_cnt
  );

  modport slave (
    input  lock, din,
    output dout, dout_valid, dout_sof, dout_eof,
    output frame_ok, frame_err, in_sync,
    output frame_cnt, err_cnt
  );
endinterface

// File: rtl/fiber_frame_deframer.sv
// Per-lane frame extractor: header hunt, payload out, good/bad counts.
// Define FIBER_DEFRAME_CSUM_EN to append and check a 16-bit sum word.
module fiber_frame_deframer #(
  parameter int          FRAME_LEN = 30,
  parameter logic [15:0] HDR_WORD  = 16'hAAAA,
  parameter int          CNT_W     = 16
) (
  input logic                  clk,
  input logic                  rst,
  fiber_frame_deframer_if.slave bus
);
  localparam int IW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    PAYLOAD
`ifdef FIBER_DEFRAME_CSUM_EN
    , CHECK
`endif
  } state_t;

  state_t           state, next;
  logic [IW-1:0]    idx;
  logic [15:0]      dout;
  logic             dout_valid;
  logic             dout_sof;
  logic             dout_eof;
  logic             frame_ok;
  logic             in_sync;
  logic [CNT_W-1:0] frame_cnt;
  logic             is_hdr;
  logic             last;

  assign is_hdr = (bus.din == HDR_WORD);
  assign last   = (idx == IW'(FRAME_LEN - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  // Next-state decode; loss of lock wins
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (bus.lock) next = HUNT;
      HUNT:    if (is_hdr) next = PAYLOAD;
`ifdef FIBER_DEFRAME_CSUM_EN
      PAYLOAD: if (last) next = CHECK;
      CHECK:   next = HUNT;
`else
      PAYLOAD: if (last) next = HUNT;
`endif
      default: next = IDLE;
    endcase
    if (!bus.lock) next = IDLE;
  end

`ifdef FIBER_DEFRAME_CSUM_EN
  logic [15:0]      acc;
  logic             frame_err;
  logic [CNT_W-1:0] err_cnt;
  logic             sum_good;

  assign sum_good = (bus.din == acc);
`endif

  // Payload path, result strobes and counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      frame_ok   <= 1'b0;
      in_sync    <= 1'b0;
      frame_cnt  <= '0;
      idx        <= '0;
`ifdef FIBER_DEFRAME_CSUM_EN
      acc        <= '0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
`endif
    end else begin
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      frame_ok   <= 1'b0;
`ifdef FIBER_DEFRAME_CSUM_EN
      frame_err  <= 1'b0;
`endif
      if (!bus.lock) begin
        in_sync <= 1'b0;
      end else begin
        unique case (state)
          HUNT: begin
            if (is_hdr) begin
              idx <= '0;
`ifdef FIBER_DEFRAME_CSUM_EN
              acc <= '0;
`endif
            end
          end
          PAYLOAD: begin
            dout       <= bus.din;
            dout_valid <= 1'b1;
            dout_sof   <= (idx == '0);
            dout_eof   <= last;
            idx        <= idx + IW'(1);
`ifdef FIBER_DEFRAME_CSUM_EN
            acc        <= acc + bus.din;
`else
            if (last) begin
              frame_ok <= 1'b1;
              in_sync  <= 1'b1;
              if (frame_cnt != '1)
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
`endif
          end
`ifdef FIBER_DEFRAME_CSUM_EN
          CHECK: begin
            if (sum_good) begin
              frame_ok <= 1'b1;
              in_sync  <= 1'b1;
              if (frame_cnt != '1)
                frame_cnt <= frame_cnt + CNT_W'(1);
            end else begin
              frame_err <= 1'b1;
              in_sync   <= 1'b0;
              if (err_cnt != '1)
                err_cnt <= err_cnt + CNT_W'(1);
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.dout_sof   = dout_sof;
  assign bus.dout_eof   = dout_eof;
  assign bus.frame_ok   = frame_ok;
  assign bus.in_sync    = in_sync;
  assign bus.frame_cnt  = frame_cnt;
`ifdef FIBER_DEFRAME_CSUM_EN
  assign bus.frame_err  = frame_err;
  assign bus.err_cnt    = err_cnt;
`else
  assign bus.frame_err  = 1'b0;
  assign bus.err_cnt    = '0;
`endif
endmodule

// File: tb/tb_fiber_frame_deframer.sv
// Directed bench for fiber_frame_deframer (FRAME_LEN=4, CNT_W=2).
// Covers both builds via FIBER_DEFRAME_CSUM_EN.
module tb_fiber_frame_deframer;
  localparam int          FL  = 4;
  localparam int          CW  = 2;
  localparam logic [15:0] HDR = 16'hAAAA;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fiber_frame_deframer_if #(.CNT_W(CW)) bus();

  fiber_frame_deframer #(
    .FRAME_LEN(FL),
    .HDR_WORD (HDR),
    .CNT_W    (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic cyc(input logic l, input logic [15:0] d);
    bus.lock = l;
    bus.din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    bus.lock = 1'b1;
    bus.din  = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Header plus FL payload words, checking each output beat
  task automatic send_frame(input logic [3:0][15:0] p);
    cyc(1'b1, HDR);
    check("hdr_no_valid", bus.dout_valid, 0);
    for (int i = 0; i < FL; i++) begin
      cyc(1'b1, p[i]);
      check("dout", bus.dout, p[i]);
      check("valid", bus.dout_valid, 1);
      check("sof", bus.dout_sof, (i == 0));
      check("eof", bus.dout_eof, (i == FL - 1));
`ifdef FIBER_DEFRAME_CSUM_EN
      check("ok_in_payload", bus.frame_ok, 0);
`else
      check("ok_with_eof", bus.frame_ok, (i == FL - 1));
`endif
    end
  endtask

`ifdef FIBER_DEFRAME_CSUM_EN
  task automatic send_csum(input logic [15:0] cs,
                           input bit good);
    cyc(1'b1, cs);
    check("csum_no_valid", bus.dout_valid, 0);
    check("frame_ok", bus.frame_ok, good);
    check("frame_err", bus.frame_err, !good);
  endtask
`endif

  task automatic good_frame(input logic [3:0][15:0] p);
    logic [15:0] s;
    s = p[0] + p[1] + p[2] + p[3];
    send_frame(p);
`ifdef FIBER_DEFRAME_CSUM_EN
    send_csum(s, 1'b1);
`else
    check("sum_seen", {16'h0, s}, {16'h0, s});
`endif
  endtask

  initial begin
    bus.lock = 1'b1;
    bus.din  = 16'h0;

    // T1: reset with lock high
    do_reset();
    check("rst_dout", bus.dout, 0);
    check("rst_valid", bus.dout_valid, 0);
    check("rst_sof", bus.dout_sof, 0);
    check("rst_eof", bus.dout_eof, 0);
    check("rst_ok", bus.frame_ok, 0);
    check("rst_err", bus.frame_err, 0);
    check("rst_sync", bus.in_sync, 0);
    check("rst_fcnt", bus.frame_cnt, 0);
    check("rst_ecnt", bus.err_cnt, 0);
    cyc(1'b1, 16'h0000);
    check("idle_valid", bus.dout_valid, 0);
    cyc(1'b1, 16'h1234);
    check("hunt_discard", bus.dout_valid, 0);

    // T2: one good frame 1..4
    good_frame({16'h0004, 16'h0003, 16'h0002, 16'h0001});
    check("t2_fcnt", bus.frame_cnt, 1);
    check("t2_sync", bus.in_sync, 1);
    cyc(1'b1, 16'h0000);
    check("gap_valid", bus.dout_valid, 0);
    check("gap_hold", bus.dout, 16'h0004);
    check("gap_ok", bus.frame_ok, 0);

`ifdef FIBER_DEFRAME_CSUM_EN
    // T3: same frame, bad checksum
    send_frame({16'h0004, 16'h0003, 16'h0002, 16'h0001});
    send_csum(16'h000B, 1'b0);
    check("t3_ecnt", bus.err_cnt, 1);
    check("t3_sync", bus.in_sync, 0);
    check("t3_fcnt", bus.frame_cnt, 1);
`endif

    // T4: lock lost mid-frame
    cyc(1'b1, HDR);
    cyc(1'b1, 16'h0001);
    check("t4_w0", bus.dout, 16'h0001);
    cyc(1'b1, 16'h0002);
    check("t4_w1", bus.dout, 16'h0002);
    cyc(1'b0, 16'h0000);
    check("t4_valid", bus.dout_valid, 0);
    check("t4_eof", bus.dout_eof, 0);
    check("t4_ok", bus.frame_ok, 0);
    check("t4_err", bus.frame_err, 0);
    check("t4_sync", bus.in_sync, 0);
    cyc(1'b0, 16'h0000);
    check("t4_fcnt", bus.frame_cnt, 1);
`ifdef FIBER_DEFRAME_CSUM_EN
    check("t4_ecnt", bus.err_cnt, 1);
`else
    check("t4_ecnt", bus.err_cnt, 0);
`endif
    cyc(1'b1, 16'h0000);
    good_frame({16'h0004, 16'h0003, 16'h0002, 16'h0001});
    check("t4_relock_fcnt", bus.frame_cnt, 2);
    check("t4_relock_sync", bus.in_sync, 1);

    // T5: back-to-back, header value as payload data
    do_reset();
    check("t5_rst_fcnt", bus.frame_cnt, 0);
    cyc(1'b1, 16'h0000);
    good_frame({16'h0004, 16'h0003, 16'h0002, 16'h0001});
    good_frame({16'h0003, 16'h0002, 16'h0001, HDR});
    check("t5_fcnt", bus.frame_cnt, 2);
    check("t5_sync", bus.in_sync, 1);

    // T6: counter saturates at 3
    for (int k = 0; k < 3; k++)
      good_frame({16'h0010, 16'h0020, 16'h0030, 16'h0040});
    check("t6_sat", bus.frame_cnt, 3);
    check("t6_ecnt", bus.err_cnt, 0);
    check("t6_sync", bus.in_sync, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end
endmodule
